// File: rtl/out_commutator_ctrl.sv
// Frame scheduler for the FFT output commutator: aligns remap lanes, emits out frame qualifiers.
// Latency: in sop at s -> remap_start at s+1 -> out_sop at s+1+FRAME_LEN+RD_LAT.
// Backpressure: none; input must be gap-free within a frame, violations pulse err and abort.
module out_commutator_ctrl #(
    parameter int FRAME_LEN = 16,
    parameter int RD_LAT    = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_sop,
    output logic             remap_start,
    output logic             out_valid,
    output logic             out_sop,
    output logic             out_eop,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] frame_cnt
);
    localparam int            AW   = $clog2(FRAME_LEN);
    localparam logic [AW-1:0] LAST = AW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, FILL, STREAM, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [AW-1:0]     wr_cnt, wr_nxt;
    logic [AW-1:0]     rd_cnt, rd_nxt;
    logic [AW-1:0]     slot_cnt;
    logic [RD_LAT-1:0] pend, pend_nxt;
    logic              start_nxt, close_nxt, err_nxt;
    logic              ov_nxt, osop_nxt, oeop_nxt;
    logic              sop_in, rd_go;

    assign sop_in = in_valid & in_sop;
    // A pulse that closes a frame reaches the lane read port RD_LAT cycles later.
    assign rd_go  = pend[RD_LAT-1];

    // Write-side state machine: frame accept, flush scheduling and framing checks.
    always_comb begin
        state_nxt = state;
        wr_nxt    = wr_cnt;
        start_nxt = 1'b0;
        close_nxt = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (sop_in) begin
                    state_nxt = FILL;
                    wr_nxt    = AW'(1);
                    start_nxt = 1'b1;
                end
            end
            FILL, STREAM: begin
                if (wr_cnt == '0) begin
                    // Frame boundary: the pulse here closes the written frame; it is either
                    // the start of a back-to-back frame or the self-generated flush.
                    start_nxt = 1'b1;
                    close_nxt = 1'b1;
                    if (sop_in) begin
                        state_nxt = STREAM;
                        wr_nxt    = AW'(1);
                    end else begin
                        state_nxt = DRAIN;
                    end
                end else if (!in_valid || (in_sop && wr_cnt != LAST)) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                    wr_nxt    = '0;
                end else begin
                    wr_nxt = wr_cnt + AW'(1);
                end
            end
            DRAIN: begin
                // A new frame may start only once the flush pulse is a full frame old.
                if (sop_in && slot_cnt == LAST) begin
                    state_nxt = FILL;
                    wr_nxt    = AW'(1);
                    start_nxt = 1'b1;
                end else if (out_eop && pend == '0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read-side sequencing: each closing pulse yields FRAME_LEN output qualifiers.
    always_comb begin
        pend_nxt    = pend << 1;
        pend_nxt[0] = close_nxt;
        rd_nxt      = rd_cnt;
        ov_nxt      = 1'b0;
        if (rd_go) begin
            ov_nxt = 1'b1;
            rd_nxt = '0;
        end else if (out_valid && rd_cnt != LAST) begin
            ov_nxt = 1'b1;
            rd_nxt = rd_cnt + AW'(1);
        end
        osop_nxt = rd_go;
        oeop_nxt = ov_nxt && (rd_nxt == LAST);
        if (err_nxt) begin
            pend_nxt = '0;
            rd_nxt   = '0;
            ov_nxt   = 1'b0;
            osop_nxt = 1'b0;
            oeop_nxt = 1'b0;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            slot_cnt    <= '0;
            pend        <= '0;
            remap_start <= 1'b0;
            out_valid   <= 1'b0;
            out_sop     <= 1'b0;
            out_eop     <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            state       <= state_nxt;
            wr_cnt      <= wr_nxt;
            rd_cnt      <= rd_nxt;
            pend        <= pend_nxt;
            remap_start <= start_nxt;
            out_valid   <= ov_nxt;
            out_sop     <= osop_nxt;
            out_eop     <= oeop_nxt;
            busy        <= (state_nxt != IDLE);
            err         <= err_nxt;
            if (start_nxt) begin
                slot_cnt <= '0;
            end else if (slot_cnt != LAST) begin
                slot_cnt <= slot_cnt + AW'(1);
            end
            if (out_eop) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end
endmodule
